button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter N_BTN, default 8, giving the number of button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the cycles of stable mismatch needed to accept a level change; legal range 2..65535.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, each raw input is inverted before synchronisation so that pressed = 1 internally.
REQ-004 The block SHALL have port clk, input, 1 bit, the sole clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port btn_raw, input, N_BTN bits, asynchronous bouncing button pins; bit order 7..0 = morse_left, morse_right, morse_tx, keypad_TL, keypad_TR, keypad_LL, keypad_LR, button_bigButton.
REQ-007 The block SHALL have port btn_clean, output, N_BTN bits, the debounced level (1 = pressed), intended to drive the button inputs of the memory-mapped button register.
REQ-008 The block SHALL have port press_pulse, output, N_BTN bits, a one-cycle strobe on each accepted 0->1 transition.
REQ-009 The block SHALL have port release_pulse, output, N_BTN bits, a one-cycle strobe on each accepted 1->0 transition.
REQ-010 The block SHALL have port press_latch, output, N_BTN bits, a sticky per-channel press flag.
REQ-011 The block SHALL have port latch_clr, input, N_BTN bits, a per-channel synchronous clear of press_latch.
REQ-012 The block SHALL have port any_press, output, 1 bit, the registered OR of press_latch.

Function
REQ-013 Each channel SHALL pass its (optionally inverted) raw bit through a 2-flop synchroniser (s1, s2) before any other logic uses it.
REQ-014 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES)) bits, saturating at no wrap.
REQ-015 Each channel SHALL have two states:
- IDLE: s2 == btn_clean, counter = 0.
- PENDING: s2 != btn_clean, counter increments each cycle.
REQ-016 In PENDING, if s2 returns equal to btn_clean, the counter SHALL clear to 0 and the channel SHALL return to IDLE on the same edge, with no output change (glitch rejection).
REQ-017 In PENDING, on the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 still differs:
- btn_clean SHALL take the value of s2.
- The counter SHALL clear to 0.
- The matching press_pulse or release_pulse bit SHALL assert for exactly that one following cycle.
REQ-018 Latency from a clean, stable raw step to the btn_clean change SHALL be exactly DEBOUNCE_CYCLES+2 clock cycles.
REQ-019 press_pulse and release_pulse for one channel SHALL never be asserted in the same cycle, and SHALL never assert outside the update edge of REQ-017.
REQ-020 press_latch[i] SHALL set on the edge after press_pulse[i] is high and clear on an edge where latch_clr[i] is high; on simultaneous set and clear, set SHALL win so no press is lost.
REQ-021 any_press SHALL equal the OR of press_latch delayed by one cycle (registered).
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be debounced and pulsed in their own cycle with no arbitration.
REQ-023 A raw pulse shorter than DEBOUNCE_CYCLES cycles (after synchronisation) SHALL produce no output activity.

Reset
REQ-024 While rst is high at a clock edge, the following SHALL be forced to 0:
- s1, s2 (the released level after optional inversion);
- counters, btn_clean, press_pulse, release_pulse, press_latch, any_press.
REQ-025 rst asserted mid-PENDING SHALL abandon the pending change with no pulse emitted.
REQ-026 A button held pressed through reset release SHALL be accepted as a fresh press DEBOUNCE_CYCLES+2 cycles after rst falls.

Verification (bench uses DEBOUNCE_CYCLES=4, N_BTN=8)
REQ-027 Clean press: btn_raw 0x00 -> 0x01 held -> btn_clean[0] rises exactly 6 cycles later; press_pulse = 0x01 for one cycle; press_latch[0] = 1 on the next cycle; any_press = 1 one cycle after that.
REQ-028 Bounce: btn_raw[7] toggles 1,0,1,0 every cycle, then holds 1 -> no output activity during the bounce; btn_clean[7] rises 6 cycles after the final hold begins, with a single press_pulse.
REQ-029 Glitch: btn_raw[3] high for 3 cycles then low -> btn_clean, pulses and latch remain 0x00 throughout.
REQ-030 Latch race: latch_clr[0] = 1 in the same cycle that press_pulse[0] sets the latch -> press_latch[0] = 1; latch_clr[0] = 1 one cycle later -> press_latch[0] = 0.
REQ-031 Reset mid-pending: raw 0xFF held, rst pulsed for 1 cycle after 3 cycles -> no pulse emitted; btn_clean = 0xFF exactly 6 cycles after rst falls, with press_pulse = 0xFF for one cycle.
REQ-032 ACTIVE_LOW=1: btn_raw 0xFF -> 0xFE -> btn_clean = 0x01 after 6 cycles; returning to 0xFF gives release_pulse = 0x01 after 6 cycles.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce
//   Per-channel debouncer for mechanical push buttons. Each raw pin is
//   optionally inverted so that 1 always means pressed. It then passes through
//   a 2-flop synchroniser. A level change is accepted only after the
//   synchronised value has differed from the accepted level for
//   DEBOUNCE_CYCLES consecutive cycles.
//
//   Ports
//     clk           : sole clock, rising edge
//     rst           : synchronous, active-high reset
//     btn_raw       : raw (asynchronous, bouncing) button pins
//     btn_clean     : debounced level, 1 = pressed
//     press_pulse   : one-cycle strobe on each accepted 0->1 change
//     release_pulse : one-cycle strobe on each accepted 1->0 change
//     press_latch   : sticky per-channel press flag
//     latch_clr     : per-channel synchronous clear of press_latch
//     any_press     : registered OR of press_latch
//
//   Channel states (decoded from the synchronised level and btn_clean)
//     state   | meaning
//     IDLE    | synchronised level equals btn_clean, counter held at 0
//     PENDING | synchronised level differs, counter runs toward acceptance
module button_debounce #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] press_latch,
  input  logic [N_BTN-1:0] latch_clr,
  output logic             any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } chan_state_t;

  logic [N_BTN-1:0] raw_in;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CW-1:0]    cnt [N_BTN];
  chan_state_t      state [N_BTN];

  // Inversion happens ahead of the synchroniser, so every later stage,
  // including the reset value, works in pressed = 1 terms.
  assign raw_in = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state[i] = (s2[i] == btn_clean[i]) ? IDLE : PENDING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= '0;
      s2            <= '0;
      btn_clean     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      press_latch   <= '0;
      any_press     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      for (int i = 0; i < N_BTN; i++) begin
        press_pulse[i]   <= 1'b0;
        release_pulse[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            cnt[i] <= '0;
          end
          PENDING: begin
            if (cnt[i] == CNT_LAST) begin
              // Acceptance edge. The counter never goes past CNT_LAST, so it cannot wrap.
              btn_clean[i]     <= s2[i];
              cnt[i]           <= '0;
              press_pulse[i]   <= s2[i];
              release_pulse[i] <= ~s2[i];
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            cnt[i] <= '0;
          end
        endcase
        // Set has priority over clear so a press that coincides with a clear is not lost.
        press_latch[i] <= press_pulse[i] | (press_latch[i] & ~latch_clr[i]);
      end
      any_press <= |press_latch;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw, clr, raw_al, clr_al;
  logic [N-1:0] clean, press, rel, latch;
  logic         any;
  logic [N-1:0] clean_al, press_al, rel_al, latch_al;
  logic         any_al;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .btn_raw(raw), .btn_clean(clean),
    .press_pulse(press), .release_pulse(rel), .press_latch(latch),
    .latch_clr(clr), .any_press(any)
  );

  button_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw_al), .btn_clean(clean_al),
    .press_pulse(press_al), .release_pulse(rel_al), .press_latch(latch_al),
    .latch_clr(clr_al), .any_press(any_al)
  );

  // Reference model. A change is accepted once the last D synchronised samples,
  // all taken since the previous acceptance, disagree with the accepted level.
  logic [N-1:0] m_s1, m_s2, m_clean, m_press, m_rel, m_latch;
  logic         m_any;
  logic         hist [N][D];
  int           nvalid [N];

  task automatic model_step(input logic r, input logic [N-1:0] rw, input logic [N-1:0] cl);
    logic [N-1:0] seen, p_old, l_old;
    bit           all_diff;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_press = '0; m_rel = '0;
      m_latch = '0; m_any = 1'b0;
      for (int c = 0; c < N; c++) nvalid[c] = 0;
    end else begin
      seen  = m_s2;
      p_old = m_press;
      l_old = m_latch;
      m_s2  = m_s1;
      m_s1  = rw;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < D - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][D-1] = seen[c];
        if (nvalid[c] < D) nvalid[c]++;
        all_diff = (nvalid[c] == D);
        for (int k = 0; k < D; k++) if (hist[c][k] == m_clean[c]) all_diff = 0;
        if (all_diff) begin
          m_clean[c] = seen[c];
          if (seen[c]) m_press[c] = 1'b1;
          else         m_rel[c]   = 1'b1;
          nvalid[c] = 0;
        end
      end
      m_latch = p_old | (l_old & ~cl);
      m_any   = |l_old;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, raw, clr);
    #1;
  endtask

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] pk(input logic [N-1:0] c, input logic [N-1:0] p,
                                     input logic [N-1:0] r, input logic [N-1:0] l,
                                     input logic a);
    return {c, p, r, l, a};
  endfunction

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] clr;
    logic [N-1:0] clean;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] latch;
    logic         any;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic [N-1:0] rw, input logic [N-1:0] cl,
                              input logic [N-1:0] c, input logic [N-1:0] p,
                              input logic [N-1:0] r, input logic [N-1:0] l,
                              input logic a);
    vec_t v;
    v.raw = rw; v.clr = cl; v.clean = c; v.press = p; v.rel = r; v.latch = l; v.any = a;
    return v;
  endfunction

  task automatic settle();
    raw = '0; clr = '1;
    for (int j = 0; j < 10; j++) tick();
    clr = '0;
    for (int j = 0; j < 2; j++) tick();
  endtask

  initial begin
    // Clean press and release of channel 0.
    for (int k = 0; k < 5; k++) tbl[k] = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[5]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
    tbl[6]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    tbl[7]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    for (int k = 8; k < 13; k++) tbl[k] = mk(8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1);
    tbl[13] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1);
    tbl[14] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    tbl[15] = mk(8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[16] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    // A 3-cycle glitch on channel 3 is one cycle short of acceptance.
    for (int k = 17; k < 20; k++) tbl[k] = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int k = 20; k < 26; k++) tbl[k] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    rst = 1'b1; raw = '0; clr = '0; raw_al = '1; clr_al = '0;
    tick(); tick();
    check("reset_state", pk(clean, press, rel, latch, any), 33'h0);
    check("reset_state_al", pk(clean_al, press_al, rel_al, latch_al, any_al), 33'h0);
    rst = 1'b0;

    for (int k = 0; k < 26; k++) begin
      raw = tbl[k].raw; clr = tbl[k].clr;
      tick();
      check($sformatf("table_row_%0d", k), pk(clean, press, rel, latch, any),
            pk(tbl[k].clean, tbl[k].press, tbl[k].rel, tbl[k].latch, tbl[k].any));
    end

    // Bounce on channel 7, then a steady hold.
    begin
      logic [N-1:0] bvals;
      bvals = 8'b0000_1010;
      for (int j = 0; j < 4; j++) begin
        raw = {bvals[3-j], 7'b0};
        tick();
        check($sformatf("bounce_quiet_%0d", j), pk(clean, press, rel, 8'h00, 1'b0), 33'h0);
      end
    end
    raw = 8'h80;
    for (int h = 1; h <= 8; h++) begin
      tick();
      check($sformatf("bounce_hold_%0d", h), pk(clean, press, rel, 8'h00, 1'b0),
            pk((h >= 6) ? 8'h80 : 8'h00, (h == 6) ? 8'h80 : 8'h00, 8'h00, 8'h00, 1'b0));
    end
    settle();

    // Clear coinciding with the set loses to the set; the next clear wins.
    raw = 8'h01;
    for (int j = 1; j <= 6; j++) tick();
    check("race_press_pulse", 33'(press), 33'h01);
    clr = 8'h01;
    tick();
    check("race_set_wins", 33'(latch[0]), 33'h1);
    tick();
    check("race_clear_next", 33'(latch[0]), 33'h0);
    clr = '0;
    settle();

    // Reset while all channels are pending.
    raw = 8'hFF;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check($sformatf("rstmid_pre_%0d", j), pk(clean, press, rel, latch, any), 33'h0);
    end
    rst = 1'b1;
    tick();
    check("rstmid_during", pk(clean, press, rel, latch, any), 33'h0);
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("rstmid_post_%0d", j), pk(clean, press, rel, 8'h00, 1'b0),
            pk((j >= 6) ? 8'hFF : 8'h00, (j == 6) ? 8'hFF : 8'h00, 8'h00, 8'h00, 1'b0));
    end
    settle();

    // Active-low instance: press and release of channel 0.
    raw_al = 8'hFE;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("al_press_%0d", j), pk(clean_al, press_al, rel_al, 8'h00, 1'b0),
            pk((j >= 6) ? 8'h01 : 8'h00, (j == 6) ? 8'h01 : 8'h00, 8'h00, 8'h00, 1'b0));
    end
    raw_al = 8'hFF;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check($sformatf("al_release_%0d", j), pk(clean_al, press_al, rel_al, 8'h00, 1'b0),
            pk((j >= 6) ? 8'h00 : 8'h01, 8'h00, (j == 6) ? 8'h01 : 8'h00, 8'h00, 1'b0));
    end

    // Randomised traffic on all channels against the model.
    for (int t = 0; t < 1500; t++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      clr = N'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      check($sformatf("random_%0d", t), pk(clean, press, rel, latch, any),
            pk(m_clean, m_press, m_rel, m_latch, m_any));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
